// File: rtl/arcade_memory_map_if.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_memory_map_if
//  Purpose  : CPU, download, video and colour port bundle for
//             arcade_memory_map. The master side is the CPU/loader/video
//             logic; the slave side is the memory subsystem.
//  Revision : 1.0  initial release
// ============================================================================
interface arcade_memory_map_if #(
    parameter int VRAM_AW = 13,
    parameter int CRAM_AW = 11
) ();
    // CPU port
    logic [15:0]        Addr;
    logic               CPU_RW_n;
    logic [7:0]         Ram_in;
    logic [7:0]         Rom_out;
    // Board configuration
    logic [1:0]         scramble;
    logic [1:0]         cmode;
    // ROM / colour download bus
    logic               dn_download;
    logic [15:0]        dn_addr;
    logic [7:0]         dn_data;
    logic               dn_wr;
    // Video port
    logic [VRAM_AW-1:0] vid_addr;
    logic [7:0]         vid_data;
    logic [7:0]         vid_next;
    // Colour lookup port
    logic [CRAM_AW-1:0] color_prom_addr;
    logic [7:0]         color_prom_out;
    // Status
    logic               ready;

    modport master (
        output Addr, CPU_RW_n, Ram_in, scramble, cmode,
        output dn_download, dn_addr, dn_data, dn_wr,
        output vid_addr, color_prom_addr,
        input  Rom_out, vid_data, vid_next, color_prom_out, ready
    );

    modport slave (
        input  Addr, CPU_RW_n, Ram_in, scramble, cmode,
        input  dn_download, dn_addr, dn_data, dn_wr,
        input  vid_addr, color_prom_addr,
        output Rom_out, vid_data, vid_next, color_prom_out, ready
    );
endinterface
`default_nettype wire

// File: rtl/arcade_memory_map.sv
`default_nettype none
// ============================================================================
//  Module   : arcade_memory_map
//  Purpose  : 8080 arcade memory subsystem: banked program ROM, work/video
//             RAM, colour PROM/RAM, address scramble, colour transforms,
//             RAM clear sequencer, registered CPU read, video look-ahead.
//  Revision : 1.0  initial release
// ============================================================================
module arcade_memory_map #(
    parameter int ROM_BANKS = 2,
    parameter int ROM_AW    = 13,
    parameter int VRAM_AW   = 13,
    parameter int CRAM_AW   = 11,
    parameter int LOOKAHEAD = 1
) (
    input  logic               clk,
    input  logic               rst,
    arcade_memory_map_if.slave bus
);

    localparam int ROM_DEPTH  = ROM_BANKS << ROM_AW;
    localparam int ROM_IW     = $clog2(ROM_DEPTH);
    localparam int VRAM_DEPTH = 1 << VRAM_AW;
    localparam int CRAM_DEPTH = 1 << CRAM_AW;

    // Clear sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    // Registered CPU read source
    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_ROM  = 2'd1;
    localparam logic [1:0] SEL_RAM  = 2'd2;
    localparam logic [1:0] SEL_CRAM = 2'd3;

    // Storage
    logic [7:0] rom_mem  [ROM_DEPTH];
    logic [7:0] vram_mem [VRAM_DEPTH];
    logic [7:0] cram_mem [CRAM_DEPTH];

    // Clear sequencer
    logic [1:0]         state_q, state_d;
    logic [VRAM_AW-1:0] counter_q, counter_d;
    logic               w_ready;
    logic               w_clear_active;

    // CPU decode
    logic [15:0]        w_eaddr;
    logic [1:0]         w_sel;
    logic [ROM_IW-1:0]  w_rom_idx;
    logic [VRAM_AW-1:0] w_ram_idx;
    logic [CRAM_AW-1:0] w_cram_cpu_idx;
    logic               w_cpu_wr;

    // Memory write ports
    logic               w_rom_we;
    logic [ROM_IW-1:0]  w_rom_waddr;
    logic               w_vram_we;
    logic [VRAM_AW-1:0] w_vram_waddr;
    logic [7:0]         w_vram_wdata;
    logic               w_cram_we;
    logic [CRAM_AW-1:0] w_cram_waddr;
    logic [7:0]         w_cram_wdata;

    // Read pipeline
    logic [1:0]         sel_q, sel_d;
    logic [7:0]         rom_rd_q, rom_rd_d;
    logic [7:0]         vram_rd_q, vram_rd_d;
    logic [7:0]         cram_rd_q, cram_rd_d;
    logic [7:0]         vid_data_q, vid_data_d;
    logic [7:0]         vid_next_q, vid_next_d;
    logic [7:0]         color_q, color_d;
    logic [7:0]         w_cprom_raw;

    // ------------------------------------------------------------------
    // Clear sequencer: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
        end
    end

    // Clear sequencer: next state; a download anywhere parks in WAIT and
    // the sweep always restarts from address 0 afterwards
    always_comb begin
        state_d   = state_q;
        counter_d = '0;
        if (bus.dn_download) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_WAIT:  state_d = ST_CLEAR;
                ST_CLEAR: begin
                    counter_d = counter_q + 1'b1;
                    if (counter_q == '1) begin
                        state_d = ST_IDLE;
                    end
                end
                default:  state_d = ST_CLEAR;
            endcase
        end
    end

    // Clear sequencer: outputs; no zero write on a cycle that aborts
    always_comb begin
        w_ready        = (state_q == ST_IDLE);
        w_clear_active = (state_q == ST_CLEAR) && !bus.dn_download;
    end

    // ------------------------------------------------------------------
    // Board address scramble applied before any CPU decoding
    always_comb begin
        w_eaddr = bus.Addr;
        case (bus.scramble)
            2'd1: w_eaddr = bus.Addr ^ 16'h0209;
            2'd2: begin
                w_eaddr[9] = bus.Addr[8];
                w_eaddr[8] = bus.Addr[9];
            end
            default: w_eaddr = bus.Addr;
        endcase
    end

    assign w_ram_idx = w_eaddr[VRAM_AW-1:0];

    // CPU region decode in priority order: colour windows, ROM, RAM
    always_comb begin
        w_sel          = SEL_NONE;
        w_rom_idx      = ROM_IW'({w_eaddr[15:14], w_eaddr[ROM_AW-1:0]});
        w_cram_cpu_idx = '0;
        if (bus.cmode[1] && (w_eaddr[15:13] == 3'b110)) begin
            w_sel          = SEL_CRAM;
            w_cram_cpu_idx = CRAM_AW'({6'd0, w_eaddr[12:8], w_eaddr[4:0]});
        end else if ((bus.cmode == 2'd1) && (w_eaddr[15:10] == 6'b010111)) begin
            w_sel          = SEL_CRAM;
            w_cram_cpu_idx = CRAM_AW'({6'd0, w_eaddr[9:0]});
        end else if ((32'(w_eaddr[15:14]) < ROM_BANKS) &&
                     ((w_eaddr[13:0] >> ROM_AW) == 14'd0)) begin
            w_sel = SEL_ROM;
        end else if (w_eaddr[15:13] == 3'b001) begin
            w_sel = SEL_RAM;
        end
    end

    assign w_cpu_wr = !bus.CPU_RW_n && w_ready;

    // ------------------------------------------------------------------
    // Write port arbitration for all three memories
    always_comb begin
        // ROM is written only by the download bus
        w_rom_we     = bus.dn_wr && (32'(bus.dn_addr) < ROM_DEPTH);
        w_rom_waddr  = ROM_IW'(bus.dn_addr);

        // RAM: clear sweep, otherwise CPU (CPU is blocked during clear)
        w_vram_we    = 1'b0;
        w_vram_waddr = w_ram_idx;
        w_vram_wdata = bus.Ram_in;
        if (w_clear_active) begin
            w_vram_we    = 1'b1;
            w_vram_waddr = counter_q;
            w_vram_wdata = 8'h00;
        end else if (w_cpu_wr && (w_sel == SEL_RAM)) begin
            w_vram_we    = 1'b1;
        end

        // Colour RAM: download wins, then clear, then CPU
        w_cram_we    = 1'b0;
        w_cram_waddr = w_cram_cpu_idx;
        w_cram_wdata = bus.Ram_in;
        if (bus.dn_wr && (32'(bus.dn_addr) >= ROM_DEPTH) &&
            (32'(bus.dn_addr) < ROM_DEPTH + CRAM_DEPTH)) begin
            w_cram_we    = 1'b1;
            w_cram_waddr = CRAM_AW'(32'(bus.dn_addr) - ROM_DEPTH);
            w_cram_wdata = bus.dn_data;
        end else if (w_clear_active && bus.cmode[1] &&
                     (32'(counter_q) < CRAM_DEPTH)) begin
            w_cram_we    = 1'b1;
            w_cram_waddr = CRAM_AW'(counter_q);
            w_cram_wdata = 8'h00;
        end else if (w_cpu_wr && (w_sel == SEL_CRAM)) begin
            w_cram_we    = 1'b1;
        end
    end

    // Memory array writes
    always_ff @(posedge clk) begin
        if (w_rom_we) begin
            rom_mem[w_rom_waddr] <= bus.dn_data;
        end
        if (w_vram_we) begin
            vram_mem[w_vram_waddr] <= w_vram_wdata;
        end
        if (w_cram_we) begin
            cram_mem[w_cram_waddr] <= w_cram_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Next values for the read pipeline; colour transform is applied
    // before the register so reset leaves the output at 0x00 in any mode
    always_comb begin
        rom_rd_d    = rom_mem[w_rom_idx];
        vram_rd_d   = vram_mem[w_ram_idx];
        cram_rd_d   = cram_mem[w_cram_cpu_idx];
        sel_d       = w_ready ? w_sel : SEL_NONE;
        vid_data_d  = vram_mem[bus.vid_addr];
        vid_next_d  = vram_mem[bus.vid_addr + VRAM_AW'(LOOKAHEAD)];
        w_cprom_raw = cram_mem[bus.color_prom_addr];
        case (bus.cmode)
            2'd1:    color_d = {w_cprom_raw[7:3], w_cprom_raw[1],
                                w_cprom_raw[2], w_cprom_raw[0]};
            2'd2:    color_d = ~w_cprom_raw;
            default: color_d = w_cprom_raw;
        endcase
    end

    // Raw memory read registers (data is ignored until sel_q picks it)
    always_ff @(posedge clk) begin
        rom_rd_q  <= rom_rd_d;
        vram_rd_q <= vram_rd_d;
        cram_rd_q <= cram_rd_d;
    end

    // Resettable output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q      <= SEL_NONE;
            vid_data_q <= 8'h00;
            vid_next_q <= 8'h00;
            color_q    <= 8'h00;
        end else begin
            sel_q      <= sel_d;
            vid_data_q <= vid_data_d;
            vid_next_q <= vid_next_d;
            color_q    <= color_d;
        end
    end

    // CPU read data mux driven by the select registered with the address
    always_comb begin
        case (sel_q)
            SEL_ROM:  bus.Rom_out = rom_rd_q;
            SEL_RAM:  bus.Rom_out = vram_rd_q;
            SEL_CRAM: bus.Rom_out = cram_rd_q;
            default:  bus.Rom_out = 8'h00;
        endcase
    end

    assign bus.vid_data       = vid_data_q;
    assign bus.vid_next       = vid_next_q;
    assign bus.color_prom_out = color_q;
    assign bus.ready          = w_ready;

endmodule
`default_nettype wire
